// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: row-multiplexed sampling, frame-level debounce and a
// single-key event FSM feeding a one-deep valid/ack event register.
module keypad_scan #(
    parameter int SCAN_DIV = 10000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clockin,
    input  logic       reset,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_held,
    output logic       overrun,
    output logic [1:0] fsm_state   // 0 RELEASED, 1 PRESSED, 2 BLOCKED
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] STAB_MAX   = CW'(DEBOUNCE);

    typedef enum logic [1:0] {
        ST_RELEASED = 2'd0,
        ST_PRESSED  = 2'd1,
        ST_BLOCKED  = 2'd2
    } state_t;

    logic [3:0]    sync1_q, sync1_d, sync2_q, sync2_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    row_q, row_d;
    logic [11:0]   snap_q, snap_d;
    logic [15:0]   prev_q, prev_d;
    logic [CW-1:0] stab_q, stab_d;
    logic [15:0]   deb_q, deb_d;
    state_t        state_q, state_d;
    logic [3:0]    rep_q, rep_d;
    logic          key_valid_q, key_valid_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          overrun_q, overrun_d;
    logic          key_held_q, key_held_d;

    logic          dwell_end, frame_end, deb_upd, deb_one, evt;
    logic [15:0]   frame_s;
    logic [3:0]    deb_idx;

    // Scan timing and snapshot assembly; row 3 is never stored because its
    // sample completes the frame and is consumed in the same cycle.
    always_comb begin
        sync1_d   = col_in;
        sync2_d   = sync1_q;
        dwell_end = (dwell_q == DWELL_LAST);
        frame_end = dwell_end && (row_q == 2'd3);
        dwell_d   = dwell_end ? '0 : dwell_q + DW'(1);
        row_d     = dwell_end ? row_q + 2'd1 : row_q;
        snap_d    = snap_q;
        if (dwell_end) begin
            case (row_q)
                2'd0:    snap_d[3:0]  = sync2_q;
                2'd1:    snap_d[7:4]  = sync2_q;
                2'd2:    snap_d[11:8] = sync2_q;
                default: snap_d       = snap_q;
            endcase
        end
        frame_s = {sync2_q, snap_q};
    end

    always_comb begin
        prev_d  = prev_q;
        stab_d  = stab_q;
        deb_d   = deb_q;
        deb_upd = 1'b0;
        if (frame_end) begin
            prev_d = frame_s;
            if (frame_s == prev_q)
                stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + CW'(1);
            else
                stab_d = '0;
            if (stab_d == STAB_MAX) begin
                deb_d   = frame_s;
                deb_upd = 1'b1;
            end
        end
    end

    always_comb begin
        deb_one = (deb_d != 16'd0) && ((deb_d & (deb_d - 16'd1)) == 16'd0);
        deb_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (deb_d[i]) deb_idx = 4'(i);
        end
    end

    // The FSM only moves on frames where the debounced state is refreshed.
    always_comb begin
        state_d = state_q;
        rep_d   = rep_q;
        evt     = 1'b0;
        if (deb_upd) begin
            case (state_q)
                ST_RELEASED: begin
                    if (deb_one) begin
                        state_d = ST_PRESSED;
                        rep_d   = deb_idx;
                        evt     = 1'b1;
                    end else if (deb_d != 16'd0) begin
                        state_d = ST_BLOCKED;
                    end
                end
                ST_PRESSED: begin
                    if (deb_d == 16'd0)
                        state_d = ST_RELEASED;
                    else if (deb_d != (16'd1 << rep_q))
                        state_d = ST_BLOCKED;
                end
                ST_BLOCKED: begin
                    if (deb_d == 16'd0) state_d = ST_RELEASED;
                end
                default: state_d = ST_RELEASED;
            endcase
        end
        key_held_d = (state_d == ST_PRESSED);
    end

    // Handshake: key_valid holds key_code steady until a cycle with key_ack=1;
    // that cycle consumes the event. A new event on a consuming cycle replaces
    // it; a new event while the old one is unconsumed is lost and flags overrun.
    always_comb begin
        key_valid_d = key_valid_q;
        key_code_d  = key_code_q;
        overrun_d   = overrun_q;
        if (evt) begin
            if (key_valid_q && !key_ack) begin
                overrun_d = 1'b1;
            end else begin
                key_valid_d = 1'b1;
                key_code_d  = deb_idx;
            end
        end else if (key_valid_q && key_ack) begin
            key_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clockin) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            dwell_q     <= '0;
            row_q       <= 2'd0;
            snap_q      <= '0;
            prev_q      <= '0;
            stab_q      <= '0;
            deb_q       <= '0;
            state_q     <= ST_RELEASED;
            rep_q       <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            overrun_q   <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            dwell_q     <= dwell_d;
            row_q       <= row_d;
            snap_q      <= snap_d;
            prev_q      <= prev_d;
            stab_q      <= stab_d;
            deb_q       <= deb_d;
            state_q     <= state_d;
            rep_q       <= rep_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            overrun_q   <= overrun_d;
            key_held_q  <= key_held_d;
        end
    end

    assign row_out   = 4'b0001 << row_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign overrun   = overrun_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE=2 (16-cycle frames);
// a keypad model drives col_in from the pressed-key map and row_out.
module tb_keypad_scan;

    logic        clockin = 1'b0;
    logic        reset;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ack;
    logic        key_held;
    logic        overrun;
    logic [1:0]  fsm_state;

    logic [15:0] keys;
    logic [3:0]  exp_row;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;

    localparam logic [15:0] S_RELEASED = 16'd0;
    localparam logic [15:0] S_PRESSED  = 16'd1;
    localparam logic [15:0] S_BLOCKED  = 16'd2;

    always #5 clockin = ~clockin;

    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
        .clockin   (clockin),
        .reset     (reset),
        .col_in    (col_in),
        .row_out   (row_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .key_held  (key_held),
        .overrun   (overrun),
        .fsm_state (fsm_state)
    );

    // Pressed key at (row, col) shorts row line to column line.
    always_comb begin
        col_in = 4'd0;
        for (int r = 0; r < 4; r++) begin
            if (row_out[r]) col_in = col_in | keys[r*4 +: 4];
        end
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called at a negedge; returns at the next negedge after one rising edge.
    task automatic step();
        @(posedge clockin);
        cyc++;
        @(negedge clockin);
    endtask

    task automatic frames(input int n);
        repeat (16 * n) step();
    endtask

    task automatic align();
        while (cyc % 16 != 0) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clockin);
        @(negedge clockin);
        reset = 1'b0;
        cyc = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        key_ack = 1'b0;
        keys    = 16'd0;
        repeat (3) @(posedge clockin);
        @(negedge clockin);
        reset = 1'b0;
        cyc   = 0;

        check("rst_row", row_out, 16'h1);
        check("rst_valid", key_valid, 16'd0);
        check("rst_code", key_code, 16'd0);
        check("rst_held", key_held, 16'd0);
        check("rst_overrun", overrun, 16'd0);
        check("rst_state", fsm_state, S_RELEASED);

        // Idle scanning: 10 frames, each row driven for 4 cycles.
        for (int i = 0; i < 160; i++) begin
            exp_row = 4'b0001 << ((cyc / 4) % 4);
            check("idle_row", row_out, exp_row);
            check("idle_valid", key_valid, 16'd0);
            step();
        end

        // Single key row 2 col 1 -> code 9 after the third frame.
        align();
        keys = 16'h0200;
        repeat (47) step();
        check("k9_pre_valid", key_valid, 16'd0);
        step();
        check("k9_valid", key_valid, 16'd1);
        check("k9_code", key_code, 16'h9);
        check("k9_held", key_held, 16'd1);
        check("k9_state", fsm_state, S_PRESSED);
        key_ack = 1'b1;
        step();
        key_ack = 1'b0;
        check("k9_ack_clear", key_valid, 16'd0);
        check("k9_held_after_ack", key_held, 16'd1);
        align();
        keys = 16'd0;
        frames(2);
        check("k9_held_2f", key_held, 16'd1);
        frames(1);
        check("k9_release", key_held, 16'd0);
        check("k9_rel_state", fsm_state, S_RELEASED);

        // Bouncing key: toggles every frame, then held stable.
        align();
        for (int f = 0; f < 8; f++) begin
            keys = (f % 2 == 0) ? 16'h0400 : 16'h0000;
            repeat (16) begin
                check("tog_valid", key_valid, 16'd0);
                step();
            end
        end
        check("tog_held", key_held, 16'd0);
        keys = 16'h0400;
        repeat (47) step();
        check("tog_pre_valid", key_valid, 16'd0);
        step();
        check("tog_valid_evt", key_valid, 16'd1);
        check("tog_code", key_code, 16'hA);
        key_ack = 1'b1;
        step();
        key_ack = 1'b0;
        align();
        repeat (32) begin
            check("tog_single_evt", key_valid, 16'd0);
            step();
        end
        check("tog_held_stable", key_held, 16'd1);
        keys = 16'd0;
        frames(3);
        check("tog_release", key_held, 16'd0);

        // Two keys together block events until a full release.
        align();
        keys = 16'h0042;
        frames(3);
        check("blk_state", fsm_state, S_BLOCKED);
        check("blk_valid", key_valid, 16'd0);
        check("blk_held", key_held, 16'd0);
        keys = 16'h0002;
        frames(3);
        check("blk_partial_state", fsm_state, S_BLOCKED);
        check("blk_partial_valid", key_valid, 16'd0);
        keys = 16'd0;
        frames(3);
        check("blk_rel_state", fsm_state, S_RELEASED);
        keys = 16'h0040;
        repeat (47) step();
        check("blk_k6_pre", key_valid, 16'd0);
        step();
        check("blk_k6_valid", key_valid, 16'd1);
        check("blk_k6_code", key_code, 16'h6);
        key_ack = 1'b1;
        step();
        key_ack = 1'b0;
        align();
        keys = 16'd0;
        frames(3);

        // Ack with nothing pending changes nothing.
        key_ack = 1'b1;
        step();
        key_ack = 1'b0;
        check("idle_ack_valid", key_valid, 16'd0);
        check("idle_ack_overrun", overrun, 16'd0);
        align();

        // Unacked key 3, then key 5 -> dropped, overrun.
        keys = 16'h0008;
        frames(3);
        check("ovr_k3_valid", key_valid, 16'd1);
        check("ovr_k3_code", key_code, 16'h3);
        check("ovr_k3_overrun", overrun, 16'd0);
        keys = 16'd0;
        frames(3);
        check("ovr_rel_valid", key_valid, 16'd1);
        check("ovr_rel_held", key_held, 16'd0);
        keys = 16'h0020;
        frames(3);
        check("ovr_valid", key_valid, 16'd1);
        check("ovr_code", key_code, 16'h3);
        check("ovr_flag", overrun, 16'd1);
        check("ovr_held", key_held, 16'd1);

        // Reset in the middle of row 2 with an event pending.
        repeat (9) step();
        check("mid_row2", row_out, 16'h4);
        keys = 16'd0;
        do_reset();
        check("mrst_row", row_out, 16'h1);
        check("mrst_valid", key_valid, 16'd0);
        check("mrst_overrun", overrun, 16'd0);
        check("mrst_held", key_held, 16'd0);
        check("mrst_code", key_code, 16'd0);
        check("mrst_state", fsm_state, S_RELEASED);

        // Key 5 arrives on the same cycle key 3 is acked -> replaced.
        keys = 16'h0008;
        frames(3);
        check("acc_k3_valid", key_valid, 16'd1);
        check("acc_k3_code", key_code, 16'h3);
        keys = 16'd0;
        frames(3);
        keys = 16'h0020;
        repeat (47) step();
        check("acc_pre_code", key_code, 16'h3);
        key_ack = 1'b1;
        step();
        key_ack = 1'b0;
        check("acc_valid", key_valid, 16'd1);
        check("acc_code", key_code, 16'h5);
        check("acc_overrun", overrun, 16'd0);
        step();
        check("acc_hold_valid", key_valid, 16'd1);
        check("acc_hold_code", key_code, 16'h5);
        key_ack = 1'b1;
        step();
        key_ack = 1'b0;
        check("acc_final_clear", key_valid, 16'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
